// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch unit. Takes the current PC from pc_reg and issues it as a
// read request to instruction memory. Each granted request advances the PC
// (pc_en_o). Every request owns a queue entry tagged with its PC. Responses
// fill the oldest unfilled entry in order. Filled entries are handed to
// decode over a valid/ready handshake.
//
// A flush discards every entry. Responses still owed for flushed requests are
// counted in r_drop and thrown away when they arrive.
//
// Optional feature (compile-time macro IFETCH_MISALIGN_CHECK_EN):
//   When defined, a PC with pc_i[1:0] != 0 raises no request. Instead it sets
//   a sticky misalign_o, which blocks fetching until a flush. When undefined,
//   pc_i[1:0] is passed through unchanged and misalign_o is tied to 0.
//
// Parameters:
//   DEPTH          queue entries: in-flight plus buffered (min 2)
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   pc_i           current PC from pc_reg
//   pc_en_o        PC accepted this cycle (pc_reg loads pc_i + 4)
//   flush_i        discard all buffered and in-flight fetches
//   imem_req_o     memory read request
//   imem_addr_o    request address (pc_i)
//   imem_gnt_i     memory accepts the request this cycle
//   imem_rvalid_i  read data valid (in order, >= 1 cycle after grant)
//   imem_rdata_i   read data
//   instr_valid_o  head instruction available
//   instr_o        head instruction word (0 when the queue is empty)
//   instr_pc_o     PC of instr_o (0 when the queue is empty)
//   instr_ready_i  decode accepts the head
//   misalign_o     misaligned-PC trap (sticky until flush or reset)
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter int DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        misalign_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Queue storage. The PC and data words are not reset; their meaning is
  // carried entirely by the control state (count/filled).
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_filled;

  logic [PW-1:0]    r_head;   // oldest entry, presented to decode
  logic [PW-1:0]    r_tail;   // next entry to allocate on grant
  logic [PW-1:0]    r_fptr;   // oldest unfilled entry, target of next response
  logic [CW-1:0]    r_count;  // allocated entries
  logic [CW-1:0]    r_nfill;  // filled entries (contiguous from head)
  logic [CW-1:0]    r_drop;   // responses still owed for flushed requests

  logic [CW:0]      w_occ;
  logic             w_room;
  logic             w_mis_pc;
  logic             w_req;
  logic             w_alloc;
  logic             w_head_filled;
  logic             w_valid;
  logic             w_pop;
  logic             w_fill;
  logic             w_drop_rsp;
  logic [CW-1:0]    w_unfilled;
  logic [CW-1:0]    w_drop_flush;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Room counts owed drops as occupied so that a dropped response can never
  // collide with a fresh one. A same-cycle pop is deliberately ignored so
  // that instr_ready_i has no combinational path to imem_req_o.
  assign w_occ  = {1'b0, r_count} + {1'b0, r_drop};
  assign w_room = (w_occ < (CW + 1)'(DEPTH));

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_mis_pc = (pc_i[1:0] != 2'b00);

  // Sets only when a request would otherwise have been raised.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_misalign <= 1'b0;
    end else if (flush_i) begin
      r_misalign <= 1'b0;
    end else if (w_room && !r_misalign && w_mis_pc) begin
      r_misalign <= 1'b1;
    end
  end

  assign misalign_o = r_misalign;
`else
  assign w_mis_pc   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign w_req   = w_room & ~flush_i & ~rst_i & ~misalign_o & ~w_mis_pc;
  assign w_alloc = w_req & imem_gnt_i;

  assign imem_req_o  = w_req;
  assign imem_addr_o = rst_i ? 32'h0 : pc_i;
  assign pc_en_o     = w_alloc;

  assign w_head_filled = (r_count != '0) & r_filled[r_head];
  assign w_valid       = w_head_filled & ~flush_i;
  assign w_pop         = w_valid & instr_ready_i;

  assign instr_valid_o = w_valid;
  assign instr_o       = w_head_filled ? r_data[r_head] : 32'h0;
  assign instr_pc_o    = (r_count != '0) ? r_pc[r_head] : 32'h0;

  // Responses go to r_drop first. A response arriving in a flush cycle is
  // consumed by the flush accounting below instead of filling an entry.
  assign w_drop_rsp = imem_rvalid_i & (r_drop != '0);
  assign w_fill     = imem_rvalid_i & (r_drop == '0) & ~flush_i;

  // Entries allocated but not yet filled become owed drops on a flush. The
  // response arriving in the same cycle settles one of those debts.
  assign w_unfilled   = r_count - r_nfill;
  assign w_drop_flush = r_drop + w_unfilled - CW'(imem_rvalid_i);

  // ---- control state ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fptr   <= '0;
      r_count  <= '0;
      r_nfill  <= '0;
      r_drop   <= '0;
      r_filled <= '0;
    end else if (flush_i) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_fptr   <= '0;
      r_count  <= '0;
      r_nfill  <= '0;
      r_filled <= '0;
      r_drop   <= w_drop_flush;
    end else begin
      // Allocation, fill and pop always touch distinct entries: fill targets
      // an unfilled entry while pop needs a filled head, and allocation never
      // happens when full.
      if (w_alloc) begin
        r_filled[r_tail] <= 1'b0;
        r_tail           <= f_inc(r_tail);
      end
      if (w_fill) begin
        r_filled[r_fptr] <= 1'b1;
        r_fptr           <= f_inc(r_fptr);
      end
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= f_inc(r_head);
      end
      r_count <= r_count + CW'(w_alloc) - CW'(w_pop);
      r_nfill <= r_nfill + CW'(w_fill) - CW'(w_pop);
      if (w_drop_rsp) begin
        r_drop <= r_drop - 1'b1;
      end
    end
  end

  // ---- queue payload ----
  always_ff @(posedge clk_i) begin
    if (w_alloc) begin
      r_pc[r_tail] <= pc_i;
    end
    if (w_fill) begin
      r_data[r_fptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready;
  logic        mis;

  ifetch_unit #(.DEPTH(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_i          (pc),
    .pc_en_o       (pc_en),
    .flush_i       (flush),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_valid_o (ivalid),
    .instr_o       (instr),
    .instr_pc_o    (ipc),
    .instr_ready_i (ready),
    .misalign_o    (mis)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  bit          dead_mode = 1'b0;
  bit          resp_en = 1'b0;
  bit          s_pcen;
  logic [31:0] pend[$];   // memory model: granted addresses awaiting response
  logic [63:0] exp_q[$];  // scoreboard: {pc, instr} expected at decode

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (dead_mode && a < 32'h200) return 32'hDEAD0000 | a;
    return a + 32'h13;
  endfunction

  // Drive the memory response for this cycle, then move to the sampling edge.
  task automatic pre();
    rvalid = resp_en && (pend.size() > 0);
    rdata  = rvalid ? memf(pend[0]) : 32'h0;
    @(negedge clk);
  endtask

  // Scoreboard and memory bookkeeping, then advance one clock (pc_reg model).
  task automatic post();
    logic [63:0] e;
    s_pcen = pc_en;
    if (flush) exp_q.delete();
    if (ivalid && ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_pop unexpected instr pc=%h instr=%h, none expected", ipc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({ipc, instr} !== e)
          $display("FAIL sb_pop got pc=%h instr=%h want pc=%h instr=%h", ipc, instr, e[63:32], e[31:0]);
        else
          n_pass++;
      end
    end
    if (rvalid) void'(pend.pop_front());
    if (pc_en) begin
      pend.push_back(pc);
      exp_q.push_back({pc, memf(pc)});
    end
    @(posedge clk);
    #1;
    if (s_pcen) pc = pc + 32'd4;
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; gnt = 1'b0; ready = 1'b0; resp_en = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; pc = 32'h0; dead_mode = 1'b0;
    pend.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; gnt = 1'b1; ready = 1'b1; resp_en = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; pc = 32'h40;
    #1;
    n_total++;
    if ({req, pc_en, ivalid, mis} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {req, pc_en, ivalid, mis});
    else n_pass++;
    n_total++;
    if (addr !== 32'h0 || instr !== 32'h0 || ipc !== 32'h0)
      $display("FAIL reset_data got addr=%h instr=%h pc=%h want 0", addr, instr, ipc);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; pc = 32'h0;
    // Fill the queue, then reset mid-flight.
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    repeat (3) step();
    n_total++;
    if (ivalid !== 1'b1) $display("FAIL pre_reset_valid got %b want 1", ivalid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({req, pc_en, ivalid, mis} !== 4'b0 || instr !== 32'h0 || ipc !== 32'h0)
      $display("FAIL async_reset got ctrl=%b instr=%h pc=%h want 0", {req, pc_en, ivalid, mis}, instr, ipc);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_first_fetch();
    do_reset();
    gnt = 1'b1; ready = 1'b1; resp_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pre();
      if (k == 0) begin
        n_total++;
        if (pc_en !== 1'b1 || addr !== 32'h0) $display("FAIL first_grant got pc_en=%b addr=%h want 1/0", pc_en, addr);
        else n_pass++;
      end
      if (k < 2) begin
        n_total++;
        if (ivalid !== 1'b0) $display("FAIL first_latency cycle %0d got valid=%b want 0", k, ivalid);
        else n_pass++;
      end else begin
        n_total++;
        if (ivalid !== 1'b1 || ipc !== 32'(4 * (k - 2)) || instr !== 32'(4 * (k - 2)) + 32'h13)
          $display("FAIL stream cycle %0d got v=%b pc=%h instr=%h want 1/%h/%h", k, ivalid, ipc, instr,
                   32'(4 * (k - 2)), 32'(4 * (k - 2)) + 32'h13);
        else n_pass++;
      end
      post();
    end
  endtask

  task automatic test_backpressure();
    int          ng;
    logic [31:0] got[$];
    ng = 0;
    do_reset();
    gnt = 1'b1; ready = 1'b0; resp_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pre();
      if (pc_en) ng++;
      post();
    end
    n_total++;
    if (ng != 3) $display("FAIL full_grants got %0d want 3", ng);
    else n_pass++;
    pre();
    n_total++;
    if (req !== 1'b0 || pc_en !== 1'b0) $display("FAIL full_noreq got req=%b pc_en=%b want 0/0", req, pc_en);
    else n_pass++;
    post();
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pre();
      if (ivalid) got.push_back(ipc);
      if (pc_en) ng++;
      post();
    end
    n_total++;
    if (got.size() < 3) $display("FAIL drain_count got %0d want >=3", got.size());
    else if (got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8)
      $display("FAIL drain_order got %h %h %h want 0 4 8", got[0], got[1], got[2]);
    else n_pass++;
    n_total++;
    if (ng <= 3) $display("FAIL resume got %0d grants want >3", ng);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    pc = 32'h100; gnt = 1'b0; ready = 1'b1; resp_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pre();
      n_total++;
      if (req !== 1'b1 || addr !== 32'h100 || pc_en !== 1'b0)
        $display("FAIL stall cycle %0d got req=%b addr=%h pc_en=%b want 1/100/0", k, req, addr, pc_en);
      else n_pass++;
      post();
    end
    gnt = 1'b1;
    pre();
    n_total++;
    if (pc_en !== 1'b1) $display("FAIL stall_grant got pc_en=%b want 1", pc_en);
    else n_pass++;
    post();
    gnt = 1'b0;
    pre();
    n_total++;
    if (pc_en !== 1'b0 || addr !== 32'h104) $display("FAIL stall_after got pc_en=%b addr=%h want 0/104", pc_en, addr);
    else n_pass++;
    post();
    gnt = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_flush();
    bit seen;
    seen = 1'b0;
    do_reset();
    dead_mode = 1'b1; gnt = 1'b1; ready = 1'b1; resp_en = 1'b0;
    step();
    step();
    flush = 1'b1; pc = 32'h200;
    pre();
    n_total++;
    if (req !== 1'b0 || ivalid !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL flush_cycle got req=%b valid=%b pc_en=%b want 0/0/0", req, ivalid, pc_en);
    else n_pass++;
    post();
    flush = 1'b0; resp_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pre();
      if (ivalid && !seen) begin
        seen = 1'b1;
        n_total++;
        if (ipc !== 32'h200 || instr !== 32'h213)
          $display("FAIL flush_first got pc=%h instr=%h want 200/213", ipc, instr);
        else n_pass++;
      end
      post();
    end
    n_total++;
    if (!seen) $display("FAIL flush_refetch got no instruction want pc 200");
    else n_pass++;
  endtask

  task automatic test_flush_rvalid();
    int  ng;
    bit  seen;
    ng = 0;
    seen = 1'b0;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    resp_en = 1'b0; step();       // grant 0x0
    resp_en = 1'b1; step();       // fill 0x0, grant 0x4
    resp_en = 1'b0; step();       // grant 0x8, queue full
    n_total++;
    if (ivalid !== 1'b1) $display("FAIL fr_head got valid=%b want 1", ivalid);
    else n_pass++;
    resp_en = 1'b1; flush = 1'b1; ready = 1'b1; pc = 32'h300;
    pre();
    n_total++;
    if (ivalid !== 1'b0 || pc_en !== 1'b0 || req !== 1'b0)
      $display("FAIL fr_flush got valid=%b pc_en=%b req=%b want 0/0/0", ivalid, pc_en, req);
    else n_pass++;
    post();
    // One response (for 0x8) is still owed, so only two new grants fit.
    flush = 1'b0; resp_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pre();
      if (pc_en) ng++;
      post();
    end
    n_total++;
    if (ng != 2) $display("FAIL fr_drop_room got %0d grants want 2", ng);
    else n_pass++;
    resp_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pre();
      if (ivalid && !seen) begin
        seen = 1'b1;
        n_total++;
        if (ipc !== 32'h300) $display("FAIL fr_first got pc=%h want 300", ipc);
        else n_pass++;
      end
      post();
    end
  endtask

  task automatic test_misalign();
    do_reset();
    pc = 32'h102; gnt = 1'b1; ready = 1'b1; resp_en = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    pre();
    n_total++;
    if (req !== 1'b0 || pc_en !== 1'b0 || mis !== 1'b0)
      $display("FAIL mis_first got req=%b pc_en=%b mis=%b want 0/0/0", req, pc_en, mis);
    else n_pass++;
    post();
    for (int k = 0; k < 3; k++) begin
      pre();
      n_total++;
      if (mis !== 1'b1 || req !== 1'b0) $display("FAIL mis_sticky got mis=%b req=%b want 1/0", mis, req);
      else n_pass++;
      post();
    end
    flush = 1'b1; pc = 32'h104;
    step();
    flush = 1'b0;
    pre();
    n_total++;
    if (mis !== 1'b0 || req !== 1'b1 || addr !== 32'h104)
      $display("FAIL mis_clear got mis=%b req=%b addr=%h want 0/1/104", mis, req, addr);
    else n_pass++;
    post();
`else
    pre();
    n_total++;
    if (req !== 1'b1 || addr !== 32'h102 || mis !== 1'b0 || pc_en !== 1'b1)
      $display("FAIL mis_off got req=%b addr=%h mis=%b pc_en=%b want 1/102/0/1", req, addr, mis, pc_en);
    else n_pass++;
    post();
`endif
    repeat (5) step();
  endtask

  task automatic test_random();
    int guard;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      gnt     = ($urandom_range(0, 3) != 0);
      resp_en = ($urandom_range(0, 2) != 0);
      ready   = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      if (flush) pc = 32'($urandom_range(0, 1023)) << 2;
      step();
    end
    flush = 1'b0; gnt = 1'b0; resp_en = 1'b1; ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || pend.size() != 0) && guard < 50) begin
      step();
      guard++;
    end
    n_total++;
    if (exp_q.size() != 0 || pend.size() != 0)
      $display("FAIL rand_drain got %0d expected and %0d pending left want 0/0", exp_q.size(), pend.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_stall();
    test_flush();
    test_flush_rvalid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit: the consumer of the PC produced by `pc_reg`. It issues the current PC as a read request to instruction memory and tells `pc_reg` when to advance (`pc_en_o`). It tags each response with its PC, buffers it in a small in-order queue and hands instruction/PC pairs to decode over a valid/ready handshake. It sits between `pc_reg`/`pc_add` and the decode stage.

## Interface
- `DEPTH`, 3, queue entries (requests in flight plus buffered instructions); min 2; 3 gives one instruction per cycle.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `pc_i`  in  32  current PC from `pc_reg`.
- `pc_en_o`  out  1  PC accepted this cycle; `pc_reg` loads `pc_i`+4.
- `flush_i`  in  1  discard all buffered and in-flight fetches (redirect).
- `imem_req_o`  out  1  memory read request.
- `imem_addr_o`  out  32  request address; equals `pc_i`.
- `imem_gnt_i`  in  1  memory accepts the request this cycle.
- `imem_rvalid_i`  in  1  read data valid; responses arrive in order, at least 1 cycle after grant.
- `imem_rdata_i`  in  32  read data.
- `instr_valid_o`  out  1  head instruction available.
- `instr_o`  out  32  instruction word.
- `instr_pc_o`  out  32  PC of `instr_o`.
- `instr_ready_i`  in  1  decode accepts the head.
- `misalign_o`  out  1  misaligned PC trap (see Configuration).

## Operation
- Queue entry = {pc, data, filled}. Grant allocates the tail entry with `pc_i`, unfilled. Each kept `imem_rvalid_i` fills the oldest unfilled entry.
- `count` = allocated entries. `drop` = responses still owed for flushed requests, range 0..DEPTH.
- `room` = (`count` + `drop`) < DEPTH. A same-cycle pop is not counted, so there is no combinational path from `instr_ready_i` to `imem_req_o`.
- `imem_req_o` = `room` & !`flush_i` & !`rst_i` & !`misalign_o` & !misaligned-PC (the last two only when the check is compiled in).
- `pc_en_o` = `imem_req_o` & `imem_gnt_i`.
- `imem_req_o` is held while `imem_gnt_i`=0. The address follows `pc_i`, which is stable because the PC does not advance until the grant.
- Response with `drop`>0: discarded, `drop` decrements. Otherwise it fills an entry.
- `instr_valid_o` = head filled & !`flush_i`. Pop when `instr_valid_o` & `instr_ready_i`. `instr_o` and `instr_pc_o` come from the head and are 0 when the queue is empty.
- Flush: all entries cleared. `drop` becomes `drop` + unfilled entries − (1 if `imem_rvalid_i` is that same cycle and would be dropped or fill). A same-cycle pop or grant is suppressed.
- Allocate and pop in the same cycle: `count` unchanged. Queue full: no request. Queue empty: no valid.
- Reset (asynchronous, any time, including mid-flight): `count`=0, `drop`=0, `misalign_o`=0. All outputs go to 0 immediately.
- Memory must not return responses for pre-reset requests after reset releases.

## Timing
- Grant in cycle T gives the earliest `rvalid` at T+1 and the earliest `instr_valid_o` at T+2 (the response is registered into the queue).
- Sustained throughput is 1 instruction/cycle with `DEPTH`≥3, `gnt`=1, `rvalid` at T+1 and `ready`=1.
- `flush_i` takes effect in its own cycle: no req, no valid. Fetch of the redirected PC starts the next cycle, once `room`.
- Counters update on the rising edge. All outputs are combinational from state plus `pc_i`/`flush_i`/`imem_gnt_i`.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - If `pc_i[1:0]`≠0 when a request would be raised, no request is issued and `misalign_o` sets on the next edge.
  - `misalign_o` is sticky until `flush_i` or reset.
  - Fetching is blocked while `misalign_o`=1. Already-queued instructions still drain.
- Undefined: `pc_i[1:0]` is ignored, the address is passed through unchanged, and `misalign_o` is tied 0.

## Test plan
- Reset then `pc_i`=0x0, `gnt`=1, `rvalid` one cycle later with rdata=0x00000013, `ready`=1 -> `instr_valid_o` at cycle 2 with instr=0x13, pc=0x0. After that, one instruction per cycle with pcs 0x4, 0x8, ….
- `ready`=0 with DEPTH=3 -> exactly 3 grants, then `imem_req_o`=0 and `pc_en_o`=0. `ready`=1 -> pcs 0x0, 0x4, 0x8 in order, then fetching resumes.
- `gnt`=0 for 4 cycles at pc=0x100 -> `imem_req_o`=1 and addr=0x100 held, `pc_en_o`=0. First grant -> `pc_en_o`=1 for that cycle only.
- 2 requests in flight, `flush_i`=1, `pc_i` redirected to 0x200 -> the next 2 responses (0xDEAD0000, 0xDEAD0004) are never presented. The first output is the 0x200 instruction.
- Flush in the same cycle as `rvalid` and `ready`=1 with a valid head -> no pop reported, that response dropped, `drop` equals the remaining in-flight count.
- With `IFETCH_MISALIGN_CHECK_EN` and `pc_i`=0x102 -> no request, `misalign_o`=1 the next cycle until `flush_i`. Without the macro -> request issued with addr=0x102 and `misalign_o`=0.
